pc_sequencer: RTL and testbench

Sequential program-counter controller for the single-cycle core. It owns the PC register, drives the instruction-memory fetch handshake, hands each fetched instruction to decode, and selects the next PC once execute reports completion. It sits between instruction memory and the decode/execute datapath. It also supplies the return address for link-register writes.

---
 rtl/pc_sequencer_pkg.sv | 18 +
 rtl/pc_sequencer_next_pc.sv | 31 +++
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the program-counter sequencer: branch-type codes,
// FSM state encoding and the PC width.
package pc_sequencer_pkg;

  localparam int PC_W = 32;

  localparam logic [2:0] BR_NONE  = 3'b000;
  localparam logic [2:0] BR_PCREL = 3'b100;
  localparam logic [2:0] BR_JALR  = 3'b101;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/pc_sequencer_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative or register-relative
// target, plus a flag for a target that is not word aligned.
module next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] imm,
  input  logic [PC_W-1:0] rs1_val,
  input  logic [2:0]      br_type,
  input  logic            br_taken,
  output logic [PC_W-1:0] next_pc,
  output logic            misalign
);

  logic [PC_W-1:0] jalr_sum;

  always_comb begin
    jalr_sum = rs1_val + imm;
    next_pc  = pc + PC_W'(4);
    if (br_taken) begin
      case (br_type)
        BR_PCREL: next_pc = pc + imm;
        // jalr drops bit 0 of the sum; bit 1 can still leave it misaligned
        BR_JALR:  next_pc = {jalr_sum[PC_W-1:1], 1'b0};
        default:  next_pc = pc + PC_W'(4);
      endcase
    end
    misalign = |next_pc[1:0];
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, fetch handshake FSM and instruction latch for the single-cycle
// core; a misaligned redirect parks the block in HALT until reset.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              stall,
  input  logic [2:0]        br_type,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   imm,
  input  logic [PC_W-1:0]   rs1_val,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   link_addr,
  output logic              misalign
);

  state_e          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [31:0]     instr_reg, instr_next;
  logic            instr_valid_reg, instr_valid_next;
  logic            misalign_reg, misalign_next;

  logic [PC_W-1:0] calc_pc;
  logic            calc_misalign;

  next_pc_calc u_next_pc (
    .pc       (pc_reg),
    .imm      (imm),
    .rs1_val  (rs1_val),
    .br_type  (br_type),
    .br_taken (br_taken),
    .next_pc  (calc_pc),
    .misalign (calc_misalign)
  );

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    instr_valid_next = 1'b0;
    misalign_next    = misalign_reg;
    case (state_reg)
      ST_RESET: state_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_next       = imem_rdata;
          instr_valid_next = 1'b1;
          state_next       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done && !stall) begin
          // a bad target keeps the PC of the offending instruction
          if (calc_misalign) begin
            misalign_next = 1'b1;
            state_next    = ST_HALT;
          end else begin
            pc_next    = calc_pc;
            state_next = ST_FETCH;
          end
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RESET;
      pc_reg          <= RESET_PC;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
      misalign_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
      misalign_reg    <= misalign_next;
    end
  end

  assign imem_req    = (state_reg == ST_FETCH);
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign link_addr   = pc_reg + PC_W'(4);
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign misalign    = misalign_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by a
// randomized instruction stream checked against a transaction-level PC model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        stall;
  logic [2:0]  br_type;
  logic        br_taken;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        misalign;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  bit          halted;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .stall       (stall),
    .br_type     (br_type),
    .br_taken    (br_taken),
    .imm         (imm),
    .rs1_val     (rs1_val),
    .pc          (pc),
    .link_addr   (link_addr),
    .misalign    (misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: where the next instruction should come from.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [2:0] bt,
                                           input logic tk, input logic [31:0] im,
                                           input logic [31:0] r1);
    logic [31:0] t;
    if (tk && bt == 3'b100)      t = cur + im;
    else if (tk && bt == 3'b101) t = (r1 + im) & 32'hFFFF_FFFE;
    else                         t = cur + 32'd4;
    return t;
  endfunction

  // Leaves the bench at a negedge in the first FETCH cycle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; exec_done = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_pc", pc, RST_PC);
    check("rst_instr", instr, 32'h0);
    check("rst_iv", instr_valid, 1'b0);
    check("rst_misalign", misalign, 1'b0);
    rst = 1'b0;
    exp_pc = RST_PC;
    halted = 1'b0;
    @(negedge clk);
    check("fetch0_req", imem_req, 1'b1);
    check("fetch0_addr", imem_addr, RST_PC);
    $display("reset: pc=%h", pc);
  endtask

  task automatic run_instr(input int wait_cyc, input int hold_cyc, input bit stall_only,
                           input logic [2:0] bt, input logic tk, input logic [31:0] im,
                           input logic [31:0] r1);
    logic [31:0] word;
    logic [31:0] target;
    word = $urandom;
    for (int i = 0; i < wait_cyc; i++) begin
      check("wait_req", imem_req, 1'b1);
      check("wait_addr", imem_addr, exp_pc);
      check("wait_iv", instr_valid, 1'b0);
      @(negedge clk);
    end
    check("ack_addr", imem_addr, exp_pc);
    imem_ack = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = $urandom;
    check("exec_iv", instr_valid, 1'b1);
    check("exec_instr", instr, word);
    check("exec_req", imem_req, 1'b0);
    check("exec_pc", pc, exp_pc);
    check("exec_link", link_addr, exp_pc + 32'd4);
    br_type = bt; br_taken = tk; imm = im; rs1_val = r1;
    for (int i = 0; i < hold_cyc; i++) begin
      if (stall_only) begin
        exec_done = 1'b1; stall = 1'b1;
      end else begin
        exec_done = 1'($urandom_range(0, 1));
        stall = exec_done ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("hold_pc", pc, exp_pc);
      check("hold_iv", instr_valid, 1'b0);
      check("hold_req", imem_req, 1'b0);
      check("hold_link", link_addr, exp_pc + 32'd4);
    end
    exec_done = 1'b1; stall = 1'b0;
    @(negedge clk);
    exec_done = 1'b0;
    target = ref_next(exp_pc, bt, tk, im, r1);
    if (target[1:0] != 2'b00) begin
      halted = 1'b1;
      check("mis_flag", misalign, 1'b1);
      check("mis_pc", pc, exp_pc);
      check("mis_req", imem_req, 1'b0);
    end else begin
      exp_pc = target;
      check("next_misalign", misalign, 1'b0);
      check("next_req", imem_req, 1'b1);
      check("next_addr", imem_addr, exp_pc);
      check("next_iv", instr_valid, 1'b0);
    end
    $display("instr: word=%h bt=%b tk=%b imm=%h rs1=%h -> target=%h halted=%0d",
             word, bt, tk, im, r1, target, halted);
  endtask

  task automatic check_halt(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      exec_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt_req", imem_req, 1'b0);
      check("halt_iv", instr_valid, 1'b0);
      check("halt_misalign", misalign, 1'b1);
      check("halt_pc", pc, exp_pc);
    end
    imem_ack = 1'b0; exec_done = 1'b0;
  endtask

  initial begin
    logic [2:0]  bt;
    logic [31:0] im;
    logic [31:0] r1;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0; stall = 1'b0;
    br_type = '0; br_taken = 1'b0; imm = '0; rs1_val = '0;
    halted = 1'b0; exp_pc = RST_PC;

    // Sequential run from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", imem_addr, 32'(i * 4));
      run_instr(0, 0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
    end
    // Taken PC-relative branch at 0x10 back to 0x08
    check("br_start", pc, 32'h10);
    run_instr(0, 0, 1'b0, 3'b100, 1'b1, 32'hFFFF_FFF8, 32'h0);
    check("br_addr", imem_addr, 32'h08);
    // jalr: (0x101 + 4) & ~1
    run_instr(0, 0, 1'b0, 3'b101, 1'b1, 32'h4, 32'h101);
    check("jalr_addr", imem_addr, 32'h104);
    // Delayed ack and stall with exec_done held
    run_instr(3, 2, 1'b1, 3'b000, 1'b0, 32'h0, 32'h0);
    check("stall_addr", imem_addr, 32'h108);
    run_instr(0, 0, 1'b0, 3'b100, 1'b1, 32'h20 - 32'h108, 32'h0);
    check("to20_addr", imem_addr, 32'h20);
    // Misaligned PC-relative target
    run_instr(0, 0, 1'b0, 3'b100, 1'b1, 32'h2, 32'h0);
    check("mis_halted", 32'(halted), 32'd1);
    check_halt(4);

    // Reset while fetching, then a late ack
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_iv", instr_valid, 1'b0);
    check("late_ack_instr", instr, 32'h0);
    check("late_ack_req", imem_req, 1'b1);
    check("late_ack_addr", imem_addr, RST_PC);
    $display("reset mid-fetch: addr=%h iv=%b", imem_addr, instr_valid);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      if (halted) begin
        check_halt(2);
        do_reset();
      end
      case ($urandom_range(0, 3))
        0: bt = 3'b000;
        1: bt = 3'b100;
        2: bt = 3'b101;
        default: bt = 3'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 15) == 0) im = $urandom;
      else im = 32'(($urandom_range(0, 63) - 32) * 4);
      r1 = $urandom;
      r1[1] = ($urandom_range(0, 7) == 0);
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, bt,
                1'($urandom_range(0, 1)), im, r1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
